// File: rtl/csr_uart_tx_if.sv
// CSR bus bundle between the pipeline (master) and the transmit UART (slave).
interface csr_uart_tx_if;
   logic        read;
   logic [2:0]  modify;
   logic [31:0] wdata;
   logic [11:0] addr;
   logic [31:0] rdata;
   logic        valid;

   modport master (output read, modify, wdata, addr, input rdata, valid);
   modport slave  (input read, modify, wdata, addr, output rdata, valid);
endinterface

// File: rtl/csr_uart_tx.sv
// CSR-mapped 8N1 transmit UART: writes queue bytes in a small FIFO, reads return TX status.
// Read data is zero when not addressed so it can be ORed into the shared CSR read bus.
module csr_uart_tx #(
   parameter logic [11:0] BASE_ADDR  = 12'hBC0,
   parameter int          DIVISOR    = 104,
   parameter int          DEPTH_LOG2 = 3
) (
   input  logic          clk,
   input  logic          rst,
   csr_uart_tx_if.slave  bus,
   output logic          tx,
   input  logic          AVOID_WARNING
);
   localparam int          DEPTH       = 2 ** DEPTH_LOG2;
   localparam logic [15:0] BAUD_RELOAD = 16'(DIVISOR - 1);

   typedef logic [DEPTH_LOG2:0] lvl_t;
   typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

   logic [11:0]           q_addr;
   logic                  hit;
   logic [7:0]            mem [DEPTH];
   logic [DEPTH_LOG2-1:0] wptr, rptr;
   lvl_t                  level;
   logic                  full, empty, overflow;
   logic                  push_req, push, pop, rd_hit;
   state_t                state, state_d;
   logic [15:0]           baud, baud_d;
   logic [2:0]            bit_idx, bit_idx_d;
   logic [7:0]            shreg, shreg_d;
   logic                  tx_d;
   logic                  unused_ok;

   function automatic logic [31:0] status_word(input logic idle, input logic is_full,
                                               input logic ovf, input lvl_t lvl);
      return {16'd0, 8'(lvl), 5'd0, ovf, is_full, idle};
   endfunction

   assign hit       = (q_addr == BASE_ADDR);
   assign full      = (level == lvl_t'(DEPTH));
   assign empty     = (level == '0);
   assign push_req  = (bus.modify == 3'd1) && hit;
   assign push      = push_req && !full;
   assign rd_hit    = bus.read && hit;
   assign pop       = (state == S_IDLE) && !empty;
   assign unused_ok = &{1'b0, AVOID_WARNING, bus.wdata[31:8]};

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         q_addr    <= '0;
         wptr      <= '0;
         rptr      <= '0;
         level     <= '0;
         overflow  <= 1'b0;
         bus.valid <= 1'b0;
         bus.rdata <= '0;
         state     <= S_IDLE;
         baud      <= '0;
         bit_idx   <= '0;
         tx        <= 1'b1;
      end else begin
         q_addr <= bus.addr;
         if (push) wptr <= wptr + 1'b1;
         if (pop)  rptr <= rptr + 1'b1;
         level <= level + lvl_t'(push) - lvl_t'(pop);
         // A dropped write in the same cycle as a status read keeps the sticky bit set.
         if (push_req && full) overflow <= 1'b1;
         else if (rd_hit)      overflow <= 1'b0;
         bus.valid <= rd_hit;
         bus.rdata <= rd_hit ? status_word(empty && (state == S_IDLE), full, overflow, level) : '0;
         state     <= state_d;
         baud      <= baud_d;
         bit_idx   <= bit_idx_d;
         tx        <= tx_d;
      end
   end

   always_ff @(posedge clk) begin
      if (push) mem[wptr] <= bus.wdata[7:0];
      shreg <= shreg_d;
   end

   // Next-state decode; tx is registered from the next state so it lines up with the FSM.
   always_comb begin
      state_d   = state;
      baud_d    = baud;
      bit_idx_d = bit_idx;
      shreg_d   = shreg;
      case (state)
         S_IDLE: begin
            if (!empty) begin
               shreg_d = mem[rptr];
               baud_d  = BAUD_RELOAD;
               state_d = S_START;
            end
         end
         S_START: begin
            if (baud == 16'd0) begin
               baud_d    = BAUD_RELOAD;
               bit_idx_d = 3'd0;
               state_d   = S_DATA;
            end else begin
               baud_d = baud - 16'd1;
            end
         end
         S_DATA: begin
            if (baud == 16'd0) begin
               baud_d    = BAUD_RELOAD;
               shreg_d   = {1'b0, shreg[7:1]};
               bit_idx_d = bit_idx + 3'd1;
               if (bit_idx == 3'd7) state_d = S_STOP;
            end else begin
               baud_d = baud - 16'd1;
            end
         end
         S_STOP: begin
            if (baud == 16'd0) state_d = S_IDLE;
            else               baud_d  = baud - 16'd1;
         end
         default: state_d = S_IDLE;
      endcase

      case (state_d)
         S_START: tx_d = 1'b0;
         S_DATA:  tx_d = shreg_d[0];
         default: tx_d = 1'b1;
      endcase
   end
endmodule

// File: tb/tb_csr_uart_tx.sv
// Bench for csr_uart_tx: cycle model built from frame arithmetic and a byte queue,
// a line receiver, directed scenarios and a randomized CSR traffic phase.
module tb_csr_uart_tx;
   localparam logic [11:0] BASE   = 12'hBC0;
   localparam int          DIV    = 4;
   localparam int          DLOG   = 3;
   localparam int          FIFO_N = 2 ** DLOG;

   logic clk = 1'b0;
   logic rst;
   logic tx;
   logic tie_off = 1'b0;
   int   errors = 0;
   int   checks = 0;

   csr_uart_tx_if bus ();

   csr_uart_tx #(.BASE_ADDR(BASE), .DIVISOR(DIV), .DEPTH_LOG2(DLOG)) dut (
      .clk(clk), .rst(rst), .bus(bus), .tx(tx), .AVOID_WARNING(tie_off)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   logic [7:0]  mq[$];
   logic        m_busy = 1'b0;
   logic [7:0]  m_cur = 8'd0;
   int          m_t = 0;
   logic        m_ovf = 1'b0;
   logic [11:0] m_qaddr = 12'd0;
   logic        m_tx = 1'b1;
   logic        m_valid = 1'b0;
   logic [31:0] m_rdata = 32'd0;
   logic        m_hit, m_full, m_wr;
   int          m_lvl;
   logic [31:0] m_st;

   // Line level at cycle t of a frame: start bit, 8 data bits LSB first, stop bit.
   function automatic logic bit_at(input logic [7:0] b, input int t);
      int k;
      k = t / DIV;
      if (k == 0) return 1'b0;
      if (k <= 8) return b[k-1];
      return 1'b1;
   endfunction

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         mq.delete();
         m_busy = 1'b0; m_t = 0; m_ovf = 1'b0; m_qaddr = 12'd0;
         m_tx = 1'b1; m_valid = 1'b0; m_rdata = 32'd0;
      end else begin
         m_hit  = (m_qaddr == BASE);
         m_lvl  = mq.size();
         m_full = (m_lvl == FIFO_N);
         m_st   = {16'd0, 8'(m_lvl), 5'd0, m_ovf, m_full, (m_lvl == 0) && !m_busy};
         m_wr   = (bus.modify == 3'd1) && m_hit;
         m_valid = bus.read && m_hit;
         m_rdata = m_valid ? m_st : 32'd0;
         if (m_wr && m_full) m_ovf = 1'b1;
         else if (bus.read && m_hit) m_ovf = 1'b0;
         if (m_busy) begin
            m_t++;
            if (m_t == 10 * DIV) m_busy = 1'b0;
         end else if (m_lvl > 0) begin
            m_cur = mq.pop_front();
            m_busy = 1'b1;
            m_t = 0;
         end
         if (m_wr && !m_full) mq.push_back(bus.wdata[7:0]);
         m_tx = m_busy ? bit_at(m_cur, m_t) : 1'b1;
         m_qaddr = bus.addr;
      end
   end

   always @(negedge clk) begin
      chk("tx", {31'd0, tx}, {31'd0, m_tx});
      chk("valid", {31'd0, bus.valid}, {31'd0, m_valid});
      chk("rdata", bus.rdata, m_rdata);
   end

   // ---------------- line receiver ----------------
   logic [7:0] rxq[$];
   logic [7:0] rx_b;
   always begin
      @(negedge clk);
      if (!rst && tx === 1'b0) begin
         repeat (DIV + DIV / 2) @(negedge clk);
         for (int k = 0; k < 8; k++) begin
            rx_b[k] = tx;
            if (k < 7) repeat (DIV) @(negedge clk);
         end
         repeat (DIV) @(negedge clk);
         rxq.push_back(rx_b);
      end
   end

   // ---------------- stimulus ----------------
   task automatic drive(input logic r, input logic [2:0] m, input logic [31:0] d);
      bus.read = r; bus.modify = m; bus.wdata = d;
      @(posedge clk); #1;
      bus.read = 1'b0; bus.modify = 3'd0;
   endtask

   task automatic idle(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic rd_expect(input string nm, input logic [31:0] exp);
      drive(1'b1, 3'd0, 32'd0);
      chk({nm, " valid"}, {31'd0, bus.valid}, 32'd1);
      chk(nm, bus.rdata, exp);
   endtask

   logic [9:0] exp_bits;
   logic [7:0] exp_list[$];

   initial begin
      rst = 1'b1;
      bus.read = 1'b0; bus.modify = 3'd0; bus.wdata = 32'd0; bus.addr = BASE;
      repeat (2) @(posedge clk);
      #1;
      chk("reset valid", {31'd0, bus.valid}, 32'd0);
      chk("reset rdata", bus.rdata, 32'd0);
      chk("reset tx", {31'd0, tx}, 32'd1);
      rst = 1'b0;
      idle(1);
      rd_expect("status after reset", 32'h0000_0001);

      // Single byte 0x55: start, 1010_1010 on the line, stop.
      rxq.delete();
      exp_bits = 10'h2AA;
      drive(1'b0, 3'd1, 32'h0000_0055);
      chk("tx before frame", {31'd0, tx}, 32'd1);
      for (int i = 0; i < 10 * DIV; i++) begin
         @(posedge clk); #1;
         chk("frame 0x55 bit", {31'd0, tx}, {31'd0, exp_bits[i / DIV]});
      end
      idle(1);
      chk("tx after frame", {31'd0, tx}, 32'd1);
      rd_expect("status after frame", 32'h0000_0001);
      idle(2);
      chk("rx count 0x55", rxq.size(), 32'd1);
      if (rxq.size() > 0) chk("rx byte 0x55", {24'd0, rxq[0]}, 32'h55);

      // Non-addressed access at BASE+1.
      bus.addr = 12'hBC1;
      idle(1);
      drive(1'b1, 3'd1, 32'h0000_00AA);
      chk("miss valid", {31'd0, bus.valid}, 32'd0);
      chk("miss rdata", bus.rdata, 32'd0);
      idle(3);
      chk("miss tx idle", {31'd0, tx}, 32'd1);
      bus.addr = BASE;
      idle(1);
      rd_expect("status after miss", 32'h0000_0001);

      // Overflow plus read/write collision.
      rxq.delete();
      for (int i = 0; i < 10; i++) drive(1'b0, 3'd1, 32'h30 + i);
      rd_expect("overflow status", 32'h0000_0806);
      rd_expect("overflow cleared", 32'h0000_0802);
      drive(1'b1, 3'd1, 32'h0000_0099);
      chk("collide valid", {31'd0, bus.valid}, 32'd1);
      chk("collide rdata", bus.rdata, 32'h0000_0802);
      rd_expect("collide sticky", 32'h0000_0806);
      rd_expect("collide cleared", 32'h0000_0802);
      idle(9 * (10 * DIV + 1) + 10);
      chk("overflow rx count", rxq.size(), 32'd9);
      for (int i = 0; i < 9; i++)
         if (i < rxq.size()) chk("overflow rx byte", {24'd0, rxq[i]}, 32'h30 + i);
      rd_expect("drained status", 32'h0000_0001);

      // Pointer wrap: 20 isolated frames.
      rxq.delete();
      exp_list.delete();
      for (int i = 0; i < 20; i++) begin
         exp_list.push_back(8'($urandom));
         drive(1'b0, 3'd1, {24'd0, exp_list[i]});
         rd_expect("wrap level", 32'h0000_0100);
         idle(10 * DIV + 2);
      end
      idle(2);
      chk("wrap rx count", rxq.size(), 32'd20);
      for (int i = 0; i < 20; i++)
         if (i < rxq.size()) chk("wrap rx byte", {24'd0, rxq[i]}, {24'd0, exp_list[i]});

      // Asynchronous reset during data bit 3 of 0xA5.
      drive(1'b0, 3'd1, 32'h0000_00A5);
      idle(17);
      #2;
      chk("tx data bit3", {31'd0, tx}, 32'd0);
      rst = 1'b1;
      #1;
      chk("tx async reset", {31'd0, tx}, 32'd1);
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      idle(1);
      rd_expect("status after mid reset", 32'h0000_0001);
      idle(50);
      rxq.delete();

      // Randomized CSR traffic against the model.
      for (int i = 0; i < 3000; i++) begin
         bus.addr   = ($urandom_range(0, 9) < 8) ? BASE : 12'($urandom_range(0, 4095));
         bus.read   = ($urandom_range(0, 9) < 3);
         bus.modify = ($urandom_range(0, 9) < 3) ? 3'd1 : 3'($urandom_range(0, 3));
         bus.wdata  = $urandom;
         @(posedge clk); #1;
      end
      bus.read = 1'b0; bus.modify = 3'd0; bus.addr = BASE;
      idle(FIFO_N * (10 * DIV + 1) + 60);
      rd_expect("final status", 32'h0000_0001);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
